// File: rtl/id_ex_hazard_reg_pkg.sv
// pipe_pkg: shared definitions for the ID/EX pipeline register slice.
// Instruction class bit map, XZR register number, FSM state type and the
// registered control bundle carried from ID to EX.
package pipe_pkg;

   localparam int unsigned NUM_CLS = 11;

   // one-hot instruction class bit indices
   localparam int unsigned CLS_ADDI = 0;
   localparam int unsigned CLS_ADDS = 1;
   localparam int unsigned CLS_AND  = 2;
   localparam int unsigned CLS_LDUR = 3;
   localparam int unsigned CLS_STUR = 4;
   localparam int unsigned CLS_B    = 5;
   localparam int unsigned CLS_EOR  = 6;
   localparam int unsigned CLS_LSL  = 7;
   localparam int unsigned CLS_LSR  = 8;
   localparam int unsigned CLS_CBZ  = 9;
   localparam int unsigned CLS_SUBS = 10;

   localparam logic [4:0] REG_XZR = 5'd31;

   typedef enum logic {RUN, FLUSH} hz_state_t;

   // Control part of the ID/EX payload; operand data is held separately so
   // its width can follow the DW parameter of the register.
   typedef struct packed {
      logic               valid;
      logic [4:0]         rn;
      logic [4:0]         rm;
      logic [4:0]         rd;
      logic [NUM_CLS-1:0] cls;
   } id_ex_t;

endpackage

// File: rtl/id_ex_hazard_reg_if.sv
// id_ex_hazard_reg_if: ID-side inputs, EX-side outputs and the IF/ID stall
// of the ID/EX register. master = pipeline control driving ID, slave = the
// register itself.
interface id_ex_hazard_reg_if #(
   parameter int unsigned DW = 64
);
   logic          id_valid;
   logic [4:0]    id_rn;
   logic [4:0]    id_rm;
   logic [4:0]    id_rd;
   logic          id_use_rn;
   logic          id_use_rm;
   logic [DW-1:0] id_rn_data;
   logic [DW-1:0] id_rm_data;
   logic [DW-1:0] id_imm;
   logic [10:0]   id_class;
   logic          ex_flush;

   logic          ex_valid;
   logic [4:0]    ex_rn;
   logic [4:0]    ex_rm;
   logic [4:0]    ex_rd;
   logic [DW-1:0] ex_rn_data;
   logic [DW-1:0] ex_rm_data;
   logic [DW-1:0] ex_imm;
   logic [10:0]   ex_class;
   logic          stall_if_id;

   modport master (
      output id_valid, id_rn, id_rm, id_rd, id_use_rn, id_use_rm,
             id_rn_data, id_rm_data, id_imm, id_class, ex_flush,
      input  ex_valid, ex_rn, ex_rm, ex_rd, ex_rn_data, ex_rm_data, ex_imm,
             ex_class, stall_if_id
   );

   modport slave (
      input  id_valid, id_rn, id_rm, id_rd, id_use_rn, id_use_rm,
             id_rn_data, id_rm_data, id_imm, id_class, ex_flush,
      output ex_valid, ex_rn, ex_rm, ex_rd, ex_rn_data, ex_rm_data, ex_imm,
             ex_class, stall_if_id
   );
endinterface

// File: rtl/id_ex_hazard_reg_load_use_detect.sv
// load_use_detect: combinational load-use hazard check between the
// instruction in ID and a load sitting in EX. XZR as destination never hazards.
module load_use_detect
   import pipe_pkg::*;
(
   input  logic               id_valid,
   input  logic [4:0]         id_rn,
   input  logic [4:0]         id_rm,
   input  logic               id_use_rn,
   input  logic               id_use_rm,
   input  logic               ex_valid,
   input  logic [NUM_CLS-1:0] ex_class,
   input  logic [4:0]         ex_rd,
   output logic               hz
);

   // hazard when ID reads the register a load in EX is about to produce
   always_comb begin
      hz = id_valid & ex_valid & ex_class[CLS_LDUR] & (ex_rd != REG_XZR) &
           ((id_use_rn & (id_rn == ex_rd)) | (id_use_rm & (id_rm == ex_rd)));
   end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// id_ex_hazard_reg: ID/EX pipeline register with load-use stall and
// branch-flush bubble injection. Priority: reset > ex_flush > hazard > capture.
// Optional build macro HAZ_STATS_EN adds saturating stall_cnt/flush_cnt outputs.
module id_ex_hazard_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DW          = 64,
   parameter int unsigned FLUSH_DEPTH = 2
) (
   input  logic                clk,
   input  logic                reset,
   id_ex_hazard_reg_if.slave   bus
`ifdef HAZ_STATS_EN
   ,
   output logic [31:0]         stall_cnt,
   output logic [31:0]         flush_cnt
`endif
);

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);

   hz_state_t     state;
   logic [2:0]    cnt;
   id_ex_t        ex_ctl;
   logic [DW-1:0] rn_data;
   logic [DW-1:0] rm_data;
   logic [DW-1:0] imm;
   logic          hz;
   logic          take;

   load_use_detect u_load_use_detect (
      .id_valid  (bus.id_valid),
      .id_rn     (bus.id_rn),
      .id_rm     (bus.id_rm),
      .id_use_rn (bus.id_use_rn),
      .id_use_rm (bus.id_use_rm),
      .ex_valid  (ex_ctl.valid),
      .ex_class  (ex_ctl.cls),
      .ex_rd     (ex_ctl.rd),
      .hz        (hz)
   );

   // stall only from RUN, never under reset or when a flush takes priority
   always_comb begin
      bus.stall_if_id = reset & (state == RUN) & ~bus.ex_flush & hz;
      take            = reset & (state == RUN) & ~bus.ex_flush & ~hz & bus.id_valid;
   end

   // flush FSM: counts remaining bubbles after a taken branch
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= RUN;
         cnt   <= '0;
      end else if (bus.ex_flush) begin
         if (FLUSH_DEPTH > 1) begin
            state <= FLUSH;
            cnt   <= FLUSH_LOAD;
         end else begin
            state <= RUN;
            cnt   <= '0;
         end
      end else if (state == FLUSH) begin
         cnt <= cnt - 3'd1;
         if (cnt <= 3'd1) begin
            state <= RUN;
         end
      end
   end

   // payload register: anything other than a real capture loads an all-zero bubble
   always_ff @(posedge clk) begin
      if (!reset || !take) begin
         ex_ctl  <= '0;
         rn_data <= '0;
         rm_data <= '0;
         imm     <= '0;
      end else begin
         ex_ctl.valid <= 1'b1;
         ex_ctl.rn    <= bus.id_rn;
         ex_ctl.rm    <= bus.id_rm;
         ex_ctl.rd    <= bus.id_rd;
         ex_ctl.cls   <= bus.id_class;
         rn_data      <= bus.id_rn_data;
         rm_data      <= bus.id_rm_data;
         imm          <= bus.id_imm;
      end
   end

   // drive the EX-side outputs from the registered payload
   always_comb begin
      bus.ex_valid   = ex_ctl.valid;
      bus.ex_rn      = ex_ctl.rn;
      bus.ex_rm      = ex_ctl.rm;
      bus.ex_rd      = ex_ctl.rd;
      bus.ex_class   = ex_ctl.cls;
      bus.ex_rn_data = rn_data;
      bus.ex_rm_data = rm_data;
      bus.ex_imm     = imm;
   end

`ifdef HAZ_STATS_EN
   // saturating event counters for stalls and accepted flushes
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (bus.stall_if_id && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (bus.ex_flush && (flush_cnt != 32'hFFFF_FFFF)) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// tb_id_ex_hazard_reg: directed bench for id_ex_hazard_reg (FLUSH_DEPTH=2).
// Honours HAZ_STATS_EN when connecting the optional counter ports.
module tb_id_ex_hazard_reg;
   import pipe_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   localparam logic [10:0] C_ADDS = 11'(1) << CLS_ADDS;
   localparam logic [10:0] C_LDUR = 11'(1) << CLS_LDUR;
   localparam logic [10:0] C_EOR  = 11'(1) << CLS_EOR;

   id_ex_hazard_reg_if #(.DW(64)) bus ();

`ifdef HAZ_STATS_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   id_ex_hazard_reg #(.DW(64), .FLUSH_DEPTH(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus)
`ifdef HAZ_STATS_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                         input logic [4:0] rd, input logic urn, input logic urm,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] im, input logic [10:0] cls);
      bus.id_valid   = v;
      bus.id_rn      = rn;
      bus.id_rm      = rm;
      bus.id_rd      = rd;
      bus.id_use_rn  = urn;
      bus.id_use_rm  = urm;
      bus.id_rn_data = a;
      bus.id_rm_data = b;
      bus.id_imm     = im;
      bus.id_class   = cls;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 64'hA, 64'hB, 64'hC, C_ADDS);
      tick();
      tick();
      n_cmp++; if (bus.ex_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0b want 0", bus.ex_valid); end
      n_cmp++; if (bus.ex_class !== 11'd0) begin n_bad++; $display("FAIL rst_class: got %0h want 0", bus.ex_class); end
      n_cmp++; if (bus.ex_rd !== 5'd0) begin n_bad++; $display("FAIL rst_rd: got %0d want 0", bus.ex_rd); end
      n_cmp++; if (bus.ex_rn_data !== 64'd0) begin n_bad++; $display("FAIL rst_data: got %0h want 0", bus.ex_rn_data); end
      n_cmp++; if (bus.stall_if_id !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %0b want 0", bus.stall_if_id); end
      reset = 1'b1;
      tick();
      n_cmp++; if (bus.ex_valid !== 1'b1) begin n_bad++; $display("FAIL rst_release_valid: got %0b want 1", bus.ex_valid); end
      n_cmp++; if (bus.ex_rd !== 5'd7) begin n_bad++; $display("FAIL rst_release_rd: got %0d want 7", bus.ex_rd); end
   endtask

   task automatic test_capture();
      set_id(1'b1, 5'd2, 5'd3, 5'd1, 1'b1, 1'b1, 64'h5, 64'h7, 64'h9, C_ADDS);
      tick();
      n_cmp++; if (bus.ex_valid !== 1'b1) begin n_bad++; $display("FAIL cap_valid: got %0b want 1", bus.ex_valid); end
      n_cmp++; if (bus.ex_rn !== 5'd2) begin n_bad++; $display("FAIL cap_rn: got %0d want 2", bus.ex_rn); end
      n_cmp++; if (bus.ex_rm !== 5'd3) begin n_bad++; $display("FAIL cap_rm: got %0d want 3", bus.ex_rm); end
      n_cmp++; if (bus.ex_rn_data !== 64'h5) begin n_bad++; $display("FAIL cap_rn_data: got %0h want 5", bus.ex_rn_data); end
      n_cmp++; if (bus.ex_rm_data !== 64'h7) begin n_bad++; $display("FAIL cap_rm_data: got %0h want 7", bus.ex_rm_data); end
      n_cmp++; if (bus.ex_imm !== 64'h9) begin n_bad++; $display("FAIL cap_imm: got %0h want 9", bus.ex_imm); end
      n_cmp++; if (bus.ex_class !== C_ADDS) begin n_bad++; $display("FAIL cap_class: got %0h want %0h", bus.ex_class, C_ADDS); end
      // an invalid ID slot captures as a bubble
      set_id(1'b0, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 64'h1, 64'h2, 64'h3, C_ADDS);
      tick();
      n_cmp++; if (bus.ex_valid !== 1'b0) begin n_bad++; $display("FAIL inv_valid: got %0b want 0", bus.ex_valid); end
      n_cmp++; if (bus.ex_rn !== 5'd0) begin n_bad++; $display("FAIL inv_rn: got %0d want 0", bus.ex_rn); end
      n_cmp++; if (bus.ex_class !== 11'd0) begin n_bad++; $display("FAIL inv_class: got %0h want 0", bus.ex_class); end
   endtask

   task automatic test_load_use();
      set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 64'h0, 64'h0, 64'h8, C_LDUR);
      tick();
      set_id(1'b1, 5'd5, 5'd2, 5'd9, 1'b1, 1'b0, 64'h11, 64'h22, 64'h0, C_ADDS);
      n_cmp++; if (bus.stall_if_id !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %0b want 1", bus.stall_if_id); end
      tick();
      n_cmp++; if (bus.ex_valid !== 1'b0) begin n_bad++; $display("FAIL lu_bubble_valid: got %0b want 0", bus.ex_valid); end
      n_cmp++; if (bus.ex_rd !== 5'd0) begin n_bad++; $display("FAIL lu_bubble_rd: got %0d want 0", bus.ex_rd); end
      n_cmp++; if (bus.stall_if_id !== 1'b0) begin n_bad++; $display("FAIL lu_stall_clear: got %0b want 0", bus.stall_if_id); end
      tick();
      n_cmp++; if (bus.ex_class !== C_ADDS || bus.ex_rn !== 5'd5) begin n_bad++; $display("FAIL lu_issue: got class %0h rn %0d want %0h rn 5", bus.ex_class, bus.ex_rn, C_ADDS); end
      // dependency through Rm
      set_id(1'b1, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, C_LDUR);
      tick();
      set_id(1'b1, 5'd2, 5'd6, 5'd3, 1'b1, 1'b1, 64'h0, 64'h0, 64'h0, C_EOR);
      n_cmp++; if (bus.stall_if_id !== 1'b1) begin n_bad++; $display("FAIL lu_rm_stall: got %0b want 1", bus.stall_if_id); end
      tick();
      tick();
      n_cmp++; if (bus.ex_class !== C_EOR) begin n_bad++; $display("FAIL lu_rm_issue: got %0h want %0h", bus.ex_class, C_EOR); end
   endtask

   task automatic test_no_stall();
      set_id(1'b1, 5'd1, 5'd0, 5'd31, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, C_LDUR);
      tick();
      set_id(1'b1, 5'd31, 5'd31, 5'd2, 1'b1, 1'b1, 64'h0, 64'h0, 64'h0, C_ADDS);
      n_cmp++; if (bus.stall_if_id !== 1'b0) begin n_bad++; $display("FAIL xzr_stall: got %0b want 0", bus.stall_if_id); end
      tick();
      set_id(1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, C_LDUR);
      tick();
      set_id(1'b1, 5'd7, 5'd4, 5'd2, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, C_ADDS);
      n_cmp++; if (bus.stall_if_id !== 1'b0) begin n_bad++; $display("FAIL unused_rm_stall: got %0b want 0", bus.stall_if_id); end
      tick();
      n_cmp++; if (bus.ex_valid !== 1'b1 || bus.ex_rm !== 5'd4) begin n_bad++; $display("FAIL unused_rm_issue: got valid %0b rm %0d want 1 rm 4", bus.ex_valid, bus.ex_rm); end
   endtask

   task automatic test_back_to_back();
      set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, C_LDUR);
      tick();
      set_id(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, C_LDUR);
      n_cmp++; if (bus.stall_if_id !== 1'b1) begin n_bad++; $display("FAIL b2b_stall1: got %0b want 1", bus.stall_if_id); end
      tick();
      tick();
      set_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, C_ADDS);
      n_cmp++; if (bus.stall_if_id !== 1'b1) begin n_bad++; $display("FAIL b2b_stall2: got %0b want 1", bus.stall_if_id); end
      tick();
      tick();
      n_cmp++; if (bus.ex_class !== C_ADDS || bus.ex_rd !== 5'd6) begin n_bad++; $display("FAIL b2b_issue: got class %0h rd %0d want %0h rd 6", bus.ex_class, bus.ex_rd, C_ADDS); end
   endtask

   task automatic test_flush();
      set_id(1'b1, 5'd2, 5'd3, 5'd1, 1'b1, 1'b1, 64'h5, 64'h6, 64'h7, C_ADDS);
      bus.ex_flush = 1'b1;
      #1;
      tick();
      bus.ex_flush = 1'b0;
      n_cmp++; if (bus.ex_valid !== 1'b0) begin n_bad++; $display("FAIL fl_bubble1: got %0b want 0", bus.ex_valid); end
      tick();
      n_cmp++; if (bus.ex_valid !== 1'b0 || bus.ex_rn_data !== 64'd0) begin n_bad++; $display("FAIL fl_bubble2: got valid %0b data %0h want 0 0", bus.ex_valid, bus.ex_rn_data); end
      tick();
      n_cmp++; if (bus.ex_valid !== 1'b1 || bus.ex_rn !== 5'd2) begin n_bad++; $display("FAIL fl_resume: got valid %0b rn %0d want 1 rn 2", bus.ex_valid, bus.ex_rn); end
      // second flush while still flushing restarts the bubble count
      bus.ex_flush = 1'b1;
      tick();
      tick();
      bus.ex_flush = 1'b0;
      n_cmp++; if (bus.ex_valid !== 1'b0) begin n_bad++; $display("FAIL fl2_bubble1: got %0b want 0", bus.ex_valid); end
      tick();
      n_cmp++; if (bus.ex_valid !== 1'b0) begin n_bad++; $display("FAIL fl2_bubble2: got %0b want 0", bus.ex_valid); end
      tick();
      n_cmp++; if (bus.ex_valid !== 1'b1) begin n_bad++; $display("FAIL fl2_resume: got %0b want 1", bus.ex_valid); end
   endtask

   task automatic test_flush_beats_hazard();
      set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, C_LDUR);
      tick();
      set_id(1'b1, 5'd5, 5'd0, 5'd2, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, C_ADDS);
      bus.ex_flush = 1'b1;
      #1;
      n_cmp++; if (bus.stall_if_id !== 1'b0) begin n_bad++; $display("FAIL fbh_stall: got %0b want 0", bus.stall_if_id); end
      tick();
      bus.ex_flush = 1'b0;
      n_cmp++; if (bus.ex_valid !== 1'b0) begin n_bad++; $display("FAIL fbh_bubble: got %0b want 0", bus.ex_valid); end
      // reset mid-flush aborts the remaining bubble
      reset = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      n_cmp++; if (bus.ex_valid !== 1'b0 || bus.ex_class !== 11'd0) begin n_bad++; $display("FAIL fbh_reset: got valid %0b class %0h want 0 0", bus.ex_valid, bus.ex_class); end
      tick();
      n_cmp++; if (bus.ex_valid !== 1'b1 || bus.ex_class !== C_ADDS) begin n_bad++; $display("FAIL fbh_after_reset: got valid %0b class %0h want 1 %0h", bus.ex_valid, bus.ex_class, C_ADDS); end
   endtask

   initial begin
      bus.ex_flush = 1'b0;
      test_reset();
      test_capture();
      test_load_use();
      test_no_stall();
      test_back_to_back();
      test_flush();
      test_flush_beats_hazard();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
